// File: rtl/fsk_tone_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : fsk_tone_analyzer
// Purpose  : Measures FSK half-period run lengths on a single-bit input,
//            classifies each run against up to four tone bins (+/- DEVIATION %)
//            and accumulates matched run lengths over a fixed window of
//            enabled cycles. At the end of each window, the per-tone totals
//            are snapshotted to the outputs together with a dominant tone index.
// Ports    : clock         - rising-edge clock
//            reset         - asynchronous active-high reset
//            enable        - 1 = measure, 0 = freeze (arming is lost)
//            sample_data   - asynchronous FSK input
//            tone_count    - per-tone tick totals of the last window,
//                            tone i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//            result_valid  - one-cycle pulse when a new snapshot appears
//            dominant_tone - index of the largest snapshot (ties -> lowest)
//            tone_detected - any snapshot nonzero
//            overflow      - an accumulator saturated in the last window
// Revision : 1.0 - initial release
// ============================================================================
module fsk_tone_analyzer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int NUM_TONES       = 2,
    parameter int FREQUENCY0      = 9000,
    parameter int FREQUENCY1      = 11000,
    parameter int FREQUENCY2      = 13000,
    parameter int FREQUENCY3      = 15000,
    parameter int DEVIATION       = 10,
    parameter int WINDOW_TICKS    = 50000,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               sample_data,
    output logic [NUM_TONES*COUNTER_WIDTH-1:0] tone_count,
    output logic                               result_valid,
    output logic [1:0]                         dominant_tone,
    output logic                               tone_detected,
    output logic                               overflow
);

    localparam int c_win_w = (WINDOW_TICKS > 2) ? $clog2(WINDOW_TICKS) : 1;
    localparam logic [c_win_w-1:0]       c_win_last = c_win_w'(WINDOW_TICKS - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_cnt_max  = '1;

    function automatic int f_freq(input int idx);
        case (idx)
            1:       return FREQUENCY1;
            2:       return FREQUENCY2;
            3:       return FREQUENCY3;
            default: return FREQUENCY0;
        endcase
    endfunction

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_prev;
    logic                     r_armed;
    logic [COUNTER_WIDTH-1:0] r_run_len;
    logic [c_win_w-1:0]       r_win;
    logic [COUNTER_WIDTH-1:0] r_acc  [NUM_TONES];
    logic [COUNTER_WIDTH-1:0] r_snap [NUM_TONES];
    logic                     r_ovf;
    logic                     r_ovf_out;
    logic                     r_valid;

    logic                     w_edge;
    logic                     w_classify;
    logic                     w_term;
    logic                     w_add_ovf;
    logic [63:0]              w_run_wide;
    logic [NUM_TONES-1:0]     w_match;
    logic [NUM_TONES-1:0]     w_hit;
    logic [NUM_TONES-1:0]     w_sat;
    logic [COUNTER_WIDTH:0]   w_sum [NUM_TONES];
    logic                     w_taken;
    logic [1:0]               w_best_idx;
    logic [COUNTER_WIDTH-1:0] w_best_val;
    logic                     w_any;

    // r_prev trails the synchronized sample so an edge is a one-cycle change.
    assign w_edge     = r_sync2 ^ r_prev;
    assign w_classify = enable & w_edge & r_armed;
    assign w_term     = enable & (r_win == c_win_last);
    assign w_run_wide = 64'(r_run_len);

    for (genvar gi = 0; gi < NUM_TONES; gi++) begin : g_tone
        localparam longint c_ticks = longint'(CLOCK_FREQUENCY) / (2 * longint'(f_freq(gi)));
        localparam longint c_dev   = c_ticks * longint'(DEVIATION) / 100;
        localparam logic [63:0] c_lo = 64'(c_ticks - c_dev);
        localparam logic [63:0] c_hi = 64'(c_ticks + c_dev);

        assign w_match[gi] = (w_run_wide >= c_lo) && (w_run_wide <= c_hi);
        assign tone_count[gi*COUNTER_WIDTH +: COUNTER_WIDTH] = r_snap[gi];
    end

    // Overlapping bins resolve to the lowest index; the sum keeps a carry bit
    // so saturation can be detected.
    always_comb begin
        w_hit   = '0;
        w_sat   = '0;
        w_taken = 1'b0;
        for (int i = 0; i < NUM_TONES; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_run_len};
            w_sat[i] = w_sum[i][COUNTER_WIDTH];
            if (w_match[i] && !w_taken) begin
                w_hit[i] = 1'b1;
                w_taken  = 1'b1;
            end
        end
    end

    assign w_add_ovf = w_classify & (|(w_hit & w_sat));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_prev    <= 1'b0;
            r_armed   <= 1'b0;
            r_run_len <= '0;
            r_win     <= '0;
            r_ovf     <= 1'b0;
            r_ovf_out <= 1'b0;
            r_valid   <= 1'b0;
            for (int i = 0; i < NUM_TONES; i++) begin
                r_acc[i]  <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            r_sync1 <= sample_data;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= 1'b0;
            if (!enable) begin
                r_armed <= 1'b0;
            end else begin
                if (w_edge) begin
                    r_run_len <= COUNTER_WIDTH'(1);
                    r_armed   <= 1'b1;
                end else if (r_run_len != c_cnt_max) begin
                    r_run_len <= r_run_len + 1'b1;
                end

                r_win <= w_term ? '0 : r_win + 1'b1;

                // On the terminal cycle the old total goes out and any edge
                // seen in that same cycle seeds the next window.
                for (int i = 0; i < NUM_TONES; i++) begin
                    if (w_term) begin
                        r_snap[i] <= r_acc[i];
                        r_acc[i]  <= (w_classify && w_hit[i]) ? r_run_len : '0;
                    end else if (w_classify && w_hit[i]) begin
                        r_acc[i]  <= w_sat[i] ? c_cnt_max : w_sum[i][COUNTER_WIDTH-1:0];
                    end
                end

                if (w_term) begin
                    r_ovf_out <= r_ovf;
                    r_ovf     <= 1'b0;
                    r_valid   <= 1'b1;
                end else if (w_add_ovf) begin
                    r_ovf     <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_best_idx = '0;
        w_best_val = r_snap[0];
        w_any      = 1'b0;
        for (int i = 1; i < NUM_TONES; i++) begin
            if (r_snap[i] > w_best_val) begin
                w_best_val = r_snap[i];
                w_best_idx = 2'(i);
            end
        end
        for (int i = 0; i < NUM_TONES; i++) begin
            if (r_snap[i] != '0) begin
                w_any = 1'b1;
            end
        end
    end

    assign dominant_tone = w_best_idx;
    assign tone_detected = w_any;
    assign overflow      = r_ovf_out;
    assign result_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fsk_tone_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsk_tone_analyzer
// Purpose  : Scoreboard bench for fsk_tone_analyzer. Stimulus is a sequence
//            of run lengths; a run/window reference model predicts every
//            snapshot and pushes it into a queue; a monitor pops and compares
//            whenever result_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsk_tone_analyzer;

    localparam int CLK_HZ = 5000000;
    localparam int NT     = 3;
    localparam int DEV    = 10;
    localparam int W      = 2000;
    localparam int CW     = 10;
    localparam int MAXV   = (1 << CW) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              sample_data = 1'b0;
    logic [NT*CW-1:0]  tone_count;
    logic              result_valid;
    logic [1:0]        dominant_tone;
    logic              tone_detected;
    logic              overflow;

    fsk_tone_analyzer #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .NUM_TONES       (NT),
        .DEVIATION       (DEV),
        .WINDOW_TICKS    (W),
        .COUNTER_WIDTH   (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .sample_data   (sample_data),
        .tone_count    (tone_count),
        .result_valid  (result_valid),
        .dominant_tone (dominant_tone),
        .tone_detected (tone_detected),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]      n;
        logic [NT*CW-1:0] cnt;
        logic [1:0]       dom;
        logic             det;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int   lo[NT];
    int   hi[NT];
    int   cur[NT];
    int   nxt[NT];
    int   tog_q[$];
    bit   armed;
    int   last_e;
    int   e_cnt;
    bit   prev_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int freq(input int i);
        case (i)
            0: return 9000;
            1: return 11000;
            2: return 13000;
            default: return 15000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            cur[i] = 0;
            nxt[i] = 0;
        end
        tog_q.delete();
        armed  = 0;
        last_e = 0;
        e_cnt  = 0;
        prev_s = 0;
    endtask

    task automatic push_expect(input int n);
        exp_t x;
        int   best;
        int   v;
        x      = '0;
        x.n    = n;
        best   = -1;
        for (int i = 0; i < NT; i++) begin
            v = (cur[i] > MAXV) ? MAXV : cur[i];
            if (cur[i] > MAXV) x.ovf = 1'b1;
            x.cnt[i*CW +: CW] = v[CW-1:0];
            if (v != 0) x.det = 1'b1;
            if (v > best) begin
                best  = v;
                x.dom = 2'(i);
            end
        end
        exp_q.push_back(x);
    endtask

    // An input change driven before posedge n is seen as an edge at posedge n+2.
    task automatic model_posedge(input int n, input bit en, input bit toggled);
        bit edge_now;
        bit term;
        bit found;
        int run;
        edge_now = 0;
        if (toggled) tog_q.push_back(n);
        while (tog_q.size() > 0 && tog_q[0] <= n - 2) begin
            if (tog_q[0] == n - 2) edge_now = 1;
            void'(tog_q.pop_front());
        end
        if (!en) begin
            armed = 0;
            return;
        end
        term = ((e_cnt % W) == W - 1);
        if (edge_now) begin
            if (armed) begin
                run   = e_cnt - last_e;
                if (run > MAXV) run = MAXV;
                found = 0;
                for (int i = 0; i < NT; i++) begin
                    if (!found && run >= lo[i] && run <= hi[i]) begin
                        found = 1;
                        if (term) nxt[i] += run;
                        else      cur[i] += run;
                    end
                end
            end
            armed  = 1;
            last_e = e_cnt;
        end
        if (term) begin
            push_expect(n);
            for (int i = 0; i < NT; i++) begin
                cur[i] = nxt[i];
                nxt[i] = 0;
            end
        end
        e_cnt++;
    endtask

    task automatic step(input bit en, input bit s);
        @(negedge clock);
        enable      = en;
        sample_data = s;
        model_posedge(cyc + 1, en, s != prev_s);
        prev_s = s;
    endtask

    task automatic do_run(input int len);
        bit s;
        s = ~prev_s;
        for (int k = 0; k < len; k++) step(1'b1, s);
    endtask

    task automatic drop_enable(input int d);
        for (int k = 0; k < d; k++) step(1'b0, prev_s);
    endtask

    function automatic int rand_len();
        int t;
        t = int'($urandom_range(0, NT - 1));
        case ($urandom_range(0, 4))
            0:       return lo[t] - 1 + int'($urandom_range(0, 2));
            1:       return hi[t] - 1 + int'($urandom_range(0, 2));
            2:       return int'($urandom_range(lo[t], hi[t]));
            3:       return int'($urandom_range(1, 140));
            default: return int'($urandom_range(306, 1200));
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tone_count"}, 64'(tone_count), 64'd0);
        chk({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        chk({tag, "_dominant_tone"}, 64'(dominant_tone), 64'd0);
        chk({tag, "_tone_detected"}, 64'(tone_detected), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && result_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_cycle", 64'(cyc), 64'(e.n));
                    for (int i = 0; i < NT; i++)
                        chk($sformatf("tone_count%0d", i), 64'(tone_count[i*CW +: CW]), 64'(e.cnt[i*CW +: CW]));
                    chk("dominant_tone", 64'(dominant_tone), 64'(e.dom));
                    chk("tone_detected", 64'(tone_detected), 64'(e.det));
                    chk("overflow", 64'(overflow), 64'(e.ovf));
                end
            end
            if (exp_q.size() > 0 && int'(exp_q[0].n) < cyc) begin
                chk("missing_result_valid", 64'd0, 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 150000", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;
        int t2;
        int bnd[$];
        for (int i = 0; i < NT; i++) begin
            t0    = CLK_HZ / (2 * freq(i));
            t1    = t0 * DEV / 100;
            lo[i] = t0 - t1;
            hi[i] = t0 + t1;
        end
        model_reset();

        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;

        // steady tone 0, steady tone 1, out-of-band tone
        t0 = CLK_HZ / (2 * freq(0));
        t1 = CLK_HZ / (2 * freq(1));
        t2 = CLK_HZ / (2 * 20000);
        repeat (22) do_run(t0);
        repeat (22) do_run(t1);
        repeat (40) do_run(t2);

        // bin edges, including one-off-outside values
        for (int i = 0; i < NT; i++) begin
            bnd.push_back(lo[i]);
            bnd.push_back(hi[i]);
            bnd.push_back(lo[i] - 1);
            bnd.push_back(hi[i] + 1);
        end
        repeat (2) begin
            foreach (bnd[k]) do_run(bnd[k]);
        end

        // random mix with enable drops
        for (int r = 0; r < 60; r++) begin
            do_run(rand_len());
            if ($urandom_range(0, 7) == 0) drop_enable(int'($urandom_range(1, 300)));
        end

        // reset in the middle of a window
        repeat (8) do_run(t0);
        @(posedge clock);
        #2;
        reset       = 1'b1;
        enable      = 1'b0;
        sample_data = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check_outputs_zero("midreset");
        @(negedge clock);
        reset = 1'b0;

        // recovery with one long freeze inside the window
        repeat (4) do_run(t0);
        drop_enable(1000);
        repeat (12) do_run(t0);
        repeat (10) do_run(t1);

        repeat (3) step(1'b1, prev_s);
        chk("pending_results", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
